// File: rtl/branch_sequencer.sv
// Fetch / conditional-branch control sequencer: walks one instruction through
// T0..T6 and raises Moore control strobes plus sticky per-instruction status.
module branch_sequencer #(
   parameter logic [4:0]  OPC_BR      = 5'b10010,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   input  logic        con,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        Zlowout,
   output logic        PCin,
   output logic        Read,
   output logic        MDatain,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Rout,
   output logic        BAout,
   output logic        CONin,
   output logic        Yin,
   output logic        Cout,
   output logic        ADD,
   output logic        busy,
   output logic        done,
   output logic        branch_taken,
   output logic        illegal,
   output logic        mem_err
);

   // state | meaning
   // IDLE  | waiting for start
   // T0    | PC -> MAR, PC+1 -> Z
   // T1    | Z -> PC (first cycle only), memory read, wait for mem_ready
   // T2    | MDR -> IR
   // T3    | opcode check, Ra -> BA path, latch condition
   // T4    | PC -> Y
   // T5    | Y + C -> Z
   // T6    | Z -> PC when condition true
   // DONE  | one-cycle completion pulse
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [3:0] wait_cnt;
   logic       is_br;
   logic       unused_ir;

   assign is_br     = (ir[31:27] == OPC_BR);
   assign unused_ir = ^ir[26:0];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_T0;
         S_T0:    state_nxt = S_T1;
         S_T1: begin
            if (mem_ready)                  state_nxt = S_T2;
            else if (wait_cnt == WAIT_LAST) state_nxt = S_DONE;
         end
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = is_br ? S_T4 : S_DONE;
         S_T4:    state_nxt = S_T5;
         S_T5:    state_nxt = S_T6;
         S_T6:    state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state        <= S_IDLE;
         wait_cnt     <= 4'd0;
         branch_taken <= 1'b0;
         illegal      <= 1'b0;
         mem_err      <= 1'b0;
      end else begin
         state <= state_nxt;

         // counter idles at zero so every T1 entry starts from a clean count
         if (state != S_T1)
            wait_cnt <= 4'd0;
         else if (!mem_ready && wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + 4'd1;

         if (state == S_IDLE && start) begin
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            mem_err      <= 1'b0;
         end
         if (state == S_T1 && !mem_ready && wait_cnt == WAIT_LAST)
            mem_err <= 1'b1;
         if (state == S_T3 && !is_br)
            illegal <= 1'b1;
         if (state == S_T6)
            branch_taken <= con;
      end
   end

   // wait_cnt is still zero only in the first T1 cycle, which gates the PC update
   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDatain = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Gra     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      CONin   = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      ADD     = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = (wait_cnt == 4'd0);
            Read    = 1'b1;
            MDatain = 1'b1;
            MDRin   = mem_ready;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Gra   = is_br;
            Rout  = is_br;
            BAout = is_br;
            CONin = is_br;
         end
         S_T4: begin
            PCout = 1'b1;
            Yin   = 1'b1;
         end
         S_T5: begin
            Cout = 1'b1;
            ADD  = 1'b1;
            Zin  = 1'b1;
         end
         S_T6: begin
            Zlowout = 1'b1;
            PCin    = con;
         end
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter OPC_BR, default 5'b10010, SHALL be the branch opcode matched against ir[31:27].
REQ-002 Parameter MEM_TIMEOUT, default 15, SHALL be the maximum number of cycles spent waiting for mem_ready (4-bit counter).
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 clr  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to begin one fetch/branch instruction cycle.
REQ-006 mem_ready  in  1  memory read data valid.
REQ-007 ir  in  32  instruction register contents; bits [31:27] are the opcode.
REQ-008 con  in  1  branch condition from the condition flip-flop stage.
REQ-009 Control outputs, each 1 bit, out: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDatain, MDRin, MDRout, IRin, Gra, Rout, BAout, CONin, Yin, Cout, ADD.
REQ-010 Status outputs, each 1 bit, out: busy, done, branch_taken, illegal, mem_err.

Function
REQ-011 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
REQ-012 Control outputs SHALL be Moore, decoded from the current state only; every control output not listed for a state SHALL be 0.
REQ-013 IDLE: no controls asserted; start=1 -> T0 next cycle; start=0 -> stay.
REQ-014 T0: PCout, MARin, IncPC, Zin asserted; -> T1 unconditionally.
REQ-015 T1: Zlowout, PCin, Read, MDatain asserted; MDRin asserted only in the cycle mem_ready=1; mem_ready=1 -> T2.
REQ-016 T1 wait counter: cleared on entry to T1; increments each T1 cycle with mem_ready=0; on reaching MEM_TIMEOUT -> DONE with mem_err=1.
REQ-017 PCin and IncPC in T1: PCin SHALL be asserted only in the first T1 cycle, so PC is updated exactly once per instruction.
REQ-018 T2: MDRout, IRin asserted; -> T3.
REQ-019 T3: when ir[31:27]==OPC_BR, assert Gra, Rout, BAout, CONin and -> T4; otherwise assert nothing and -> DONE with illegal=1.
REQ-020 T4: PCout, Yin asserted; -> T5.
REQ-021 T5: Cout, ADD, Zin asserted; -> T6.
REQ-022 T6: Zlowout asserted; PCin asserted iff con=1; branch_taken SHALL be registered from con at the end of T6; -> DONE.
REQ-023 con SHALL be treated as valid only from T4 onward, one edge after CONin; con SHALL be ignored in all other states.
REQ-024 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 branch_taken, illegal and mem_err SHALL hold their value from DONE until the next entry to T0, which clears all three.
REQ-027 start while busy=1 SHALL be ignored; no request SHALL be queued.
REQ-028 start=1 in the DONE cycle SHALL be ignored; the next instruction requires start=1 in IDLE.
REQ-029 Instruction latency with mem_ready=1 on the first T1 cycle SHALL be 8 cycles from the start edge to done=1.

Reset
REQ-030 clr=0 SHALL force IDLE immediately, independent of clk.
REQ-031 During and after reset, every control and status output SHALL be 0 and the wait counter SHALL be 0.
REQ-032 Reset asserted in any state mid-instruction SHALL abandon the instruction with no further control pulses.
REQ-033 After clr returns to 1, the first state change SHALL occur no earlier than the first rising clk edge.

Verification
REQ-034 Taken branch: ir[31:27]=10010, con=1, mem_ready=1 in T1 -> PCin in T1 and T6; done at cycle 8; branch_taken=1.
REQ-035 Not-taken branch: same as REQ-034 with con=0 -> PCin in T1 only; done at cycle 8; branch_taken=0.
REQ-036 Memory wait: mem_ready rises after 3 T1 cycles -> T1 lasts 4 cycles; MDRin pulses once; PCin asserted in the first T1 cycle only; done at cycle 11.
REQ-037 Timeout: mem_ready held 0 -> mem_err=1 after 15 T1 cycles; done for 1 cycle; T2 never entered.
REQ-038 Illegal opcode: ir[31:27]=00011 -> CONin never asserted; illegal=1; done at cycle 5.
REQ-039 Reset mid-operation: clr=0 during T4 -> all outputs 0 immediately; IDLE; a subsequent start runs a full, clean instruction.
